// File: rtl/sa_skew_feeder_pkg.sv
// Shared types and elaboration-time helpers for the systolic-array skew feeder.
// Derived widths (KW, CW) and skew lane count (L) are computed by the calc_* functions.
package sa_feed_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // KW: width of the depth field
   function automatic int unsigned calc_kw(input int unsigned m_dim);
      return clog2(m_dim + 1);
   endfunction

   // CW: width of the beat counter, sized so it can never wrap
   function automatic int unsigned calc_cw(input int unsigned m_dim, input int unsigned x_r,
                                           input int unsigned w_c);
      return clog2(m_dim + max(x_r, w_c) + 1);
   endfunction

   // L: number of beats the skewed wavefront spans
   function automatic int unsigned calc_l(input int unsigned skew_en, input int unsigned x_r,
                                          input int unsigned w_c);
      return (skew_en != 0) ? max(x_r, w_c) : 1;
   endfunction

endpackage

// File: rtl/sa_lane_select.sv
// One output lane: picks the element for the current beat from a row/column slice,
// or 0 when the lane's skewed beat falls outside the active depth.
module sa_lane_select
   import sa_feed_pkg::*;
#(
   parameter int unsigned D_W   = 16,
   parameter int unsigned M_DIM = 64,
   parameter int unsigned C_W   = 7,
   parameter int unsigned K_W   = 7
) (
   input  logic [C_W-1:0]       beat,
   input  logic [C_W-1:0]       offset,
   input  logic [K_W-1:0]       k_len,
   input  logic                 rev,
   input  logic [M_DIM*D_W-1:0] slice,
   output logic [D_W-1:0]       elem_c
);

   localparam int unsigned I_W = max(clog2(M_DIM), 1);
   localparam int unsigned R_W = max(C_W, K_W) + 1;

   logic [D_W-1:0] elems [M_DIM];
   logic [R_W-1:0] kk_c;
   logic [R_W-1:0] kdepth_c;
   logic [I_W-1:0] idx_c;

   for (genvar gk = 0; gk < M_DIM; gk++) begin : g_elem
      assign elems[gk] = slice[gk*D_W +: D_W];
   end

   // beat < offset is tested directly so a lane that has not started never wraps into range
   always_comb begin
      kk_c     = R_W'(beat) - R_W'(offset);
      kdepth_c = R_W'(k_len);
      idx_c    = rev ? I_W'(kdepth_c - R_W'(1) - kk_c) : I_W'(kk_c);
      elem_c   = '0;
      if ((beat >= offset) && (kk_c < kdepth_c)) begin
         elem_c = elems[idx_c];
      end
   end

endmodule

// File: rtl/sa_skew_feeder.sv
// Streams X columns and W rows into the SA PE grid, one registered vector per shift beat,
// with programmable depth, optional diagonal skew and reversible k-order.
module sa_skew_feeder
   import sa_feed_pkg::*;
#(
   parameter int unsigned  D_W     = 16,
   parameter int unsigned  X_R     = 16,
   parameter int unsigned  M_DIM   = 64,
   parameter int unsigned  W_C     = 16,
   parameter int unsigned  SKEW_EN = 1,
   localparam int unsigned K_W     = calc_kw(M_DIM)
) (
   input  logic                       I_CLK,
   input  logic                       I_SYNC_RST,
   input  logic                       I_START,
   input  logic [K_W-1:0]             I_K_LEN,
   input  logic                       I_REVERSE,
   input  logic                       I_PE_SHIFT,
   input  logic [X_R*M_DIM*D_W-1:0]   I_X_MATRIX,
   input  logic [M_DIM*W_C*D_W-1:0]   I_W_MATRIX,
   output logic [X_R*D_W-1:0]         O_X_VECTOR,
   output logic [W_C*D_W-1:0]         O_W_VECTOR,
   output logic                       O_BUSY,
   output logic                       O_OVER
);

   localparam int unsigned C_W   = calc_cw(M_DIM, X_R, W_C);
   localparam int unsigned LANES = calc_l(SKEW_EN, X_R, W_C);

   state_t             state_q, state_d;
   logic [C_W-1:0]     beat_q, beat_d;
   logic [K_W-1:0]     k_q, k_d;
   logic               rev_q, rev_d;
   logic [X_R*D_W-1:0] x_q, x_d;
   logic [W_C*D_W-1:0] w_q, w_d;
   logic               busy_q, busy_d;
   logic               over_q, over_d;

   logic [K_W-1:0]       k_in_c;
   logic [C_W-1:0]       last_beat_c;
   logic [X_R*D_W-1:0]   x_lane_c;
   logic [W_C*D_W-1:0]   w_lane_c;
   logic [M_DIM*D_W-1:0] w_col [W_C];

   assign k_in_c      = (I_K_LEN > K_W'(M_DIM)) ? K_W'(M_DIM) : I_K_LEN;
   assign last_beat_c = C_W'(k_q) + C_W'(LANES) - C_W'(2);

   for (genvar gi = 0; gi < X_R; gi++) begin : g_x_lane
      localparam int unsigned OFF = (SKEW_EN != 0) ? gi : 0;
      sa_lane_select #(
         .D_W   (D_W),
         .M_DIM (M_DIM),
         .C_W   (C_W),
         .K_W   (K_W)
      ) u_sel (
         .beat   (beat_q),
         .offset (C_W'(OFF)),
         .k_len  (k_q),
         .rev    (rev_q),
         .slice  (I_X_MATRIX[gi*M_DIM*D_W +: M_DIM*D_W]),
         .elem_c (x_lane_c[gi*D_W +: D_W])
      );
   end

   // W columns are strided in the flat bus; gather each into a contiguous slice
   for (genvar gj = 0; gj < W_C; gj++) begin : g_w_lane
      localparam int unsigned OFF = (SKEW_EN != 0) ? gj : 0;
      for (genvar gk = 0; gk < M_DIM; gk++) begin : g_gather
         assign w_col[gj][gk*D_W +: D_W] = I_W_MATRIX[(gk*W_C+gj)*D_W +: D_W];
      end
      sa_lane_select #(
         .D_W   (D_W),
         .M_DIM (M_DIM),
         .C_W   (C_W),
         .K_W   (K_W)
      ) u_sel (
         .beat   (beat_q),
         .offset (C_W'(OFF)),
         .k_len  (k_q),
         .rev    (rev_q),
         .slice  (w_col[gj]),
         .elem_c (w_lane_c[gj*D_W +: D_W])
      );
   end

   // Next-state and output-register loads
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      k_d     = k_q;
      rev_d   = rev_q;
      x_d     = x_q;
      w_d     = w_q;
      over_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            x_d    = '0;
            w_d    = '0;
            beat_d = '0;
            if (I_START) begin
               if (k_in_c != '0) begin
                  k_d     = k_in_c;
                  rev_d   = I_REVERSE;
                  state_d = S_RUN;
               end else begin
                  over_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (I_PE_SHIFT) begin
               x_d    = x_lane_c;
               w_d    = w_lane_c;
               beat_d = beat_q + C_W'(1);
               if (beat_q == last_beat_c) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (I_PE_SHIFT) begin
               x_d     = '0;
               w_d     = '0;
               over_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge I_CLK) begin
      if (I_SYNC_RST) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         k_q     <= '0;
         rev_q   <= 1'b0;
         x_q     <= '0;
         w_q     <= '0;
         busy_q  <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         k_q     <= k_d;
         rev_q   <= rev_d;
         x_q     <= x_d;
         w_q     <= w_d;
         busy_q  <= busy_d;
         over_q  <= over_d;
      end
   end

   assign O_X_VECTOR = x_q;
   assign O_W_VECTOR = w_q;
   assign O_BUSY     = busy_q;
   assign O_OVER     = over_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Randomised bench for sa_skew_feeder: an aligned and a skewed instance checked against
// a per-beat model of which matrix element each lane should present.
module tb_sa_skew_feeder;

   localparam int unsigned D_W   = 16;
   localparam int unsigned X_R   = 2;
   localparam int unsigned M_DIM = 4;
   localparam int unsigned W_C   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start;
   logic [2:0]  k_len;
   logic        rev;
   logic        shift;
   logic [X_R*M_DIM*D_W-1:0] xmat;
   logic [M_DIM*W_C*D_W-1:0] wmat;

   logic [31:0] xv0, xv1, wv0, wv1;
   logic        busy0, busy1, over0, over1;

   logic [15:0] xm [2][4];
   logic [15:0] wm [4][2];

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   sa_skew_feeder #(.D_W(D_W), .X_R(X_R), .M_DIM(M_DIM), .W_C(W_C), .SKEW_EN(0)) u_dut0 (
      .I_CLK(clk), .I_SYNC_RST(rst), .I_START(start[0]), .I_K_LEN(k_len),
      .I_REVERSE(rev), .I_PE_SHIFT(shift), .I_X_MATRIX(xmat), .I_W_MATRIX(wmat),
      .O_X_VECTOR(xv0), .O_W_VECTOR(wv0), .O_BUSY(busy0), .O_OVER(over0)
   );

   sa_skew_feeder #(.D_W(D_W), .X_R(X_R), .M_DIM(M_DIM), .W_C(W_C), .SKEW_EN(1)) u_dut1 (
      .I_CLK(clk), .I_SYNC_RST(rst), .I_START(start[1]), .I_K_LEN(k_len),
      .I_REVERSE(rev), .I_PE_SHIFT(shift), .I_X_MATRIX(xmat), .I_W_MATRIX(wmat),
      .O_X_VECTOR(xv1), .O_W_VECTOR(wv1), .O_BUSY(busy1), .O_OVER(over1)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   // Element index seen by a lane at beat b, or -1 when the lane should carry 0
   function automatic int lane_idx(input int skew, input int lane, input int b, input int k,
                                   input bit r);
      int kk;
      kk = b - ((skew != 0) ? lane : 0);
      if (kk < 0 || kk >= k) return -1;
      return r ? (k - 1 - kk) : kk;
   endfunction

   function automatic logic [31:0] exp_x(input int skew, input int b, input int k, input bit r);
      logic [31:0] v;
      int idx;
      v = '0;
      for (int i = 0; i < 2; i++) begin
         idx = lane_idx(skew, i, b, k, r);
         if (idx >= 0) v[i*16 +: 16] = xm[i][idx];
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_w(input int skew, input int b, input int k, input bit r);
      logic [31:0] v;
      int idx;
      v = '0;
      for (int j = 0; j < 2; j++) begin
         idx = lane_idx(skew, j, b, k, r);
         if (idx >= 0) v[j*16 +: 16] = wm[idx][j];
      end
      return v;
   endfunction

   task automatic observe(input int sel, input logic [31:0] ex, input logic [31:0] ew,
                          input bit eb, input bit eo, input string tag);
      check_val({tag, "_x"}, (sel != 0) ? xv1 : xv0, ex);
      check_val({tag, "_w"}, (sel != 0) ? wv1 : wv0, ew);
      check_val({tag, "_busy"}, 32'((sel != 0) ? busy1 : busy0), 32'(eb));
      check_val({tag, "_over"}, 32'((sel != 0) ? over1 : over0), 32'(eo));
   endtask

   task automatic load_matrix(input bit rnd);
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++)
            xm[i][k] = rnd ? 16'($urandom) : 16'(16*i + k);
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 2; j++)
            wm[k][j] = rnd ? 16'($urandom) : 16'(256*k + j);
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++)
            xmat[(i*4+k)*16 +: 16] = xm[i][k];
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 2; j++)
            wmat[(k*2+j)*16 +: 16] = wm[k][j];
   endtask

   task automatic run(input int sel, input int klen, input bit r, input int gapmax,
                      input int rst_at);
      int k;
      int t;
      int shifts;
      int gap;
      logic [31:0] hx;
      logic [31:0] hw;
      k      = (klen > 4) ? 4 : klen;
      t      = k + ((sel != 0) ? 2 : 1) - 1;
      shifts = 0;
      hx     = '0;
      hw     = '0;
      k_len      = 3'(klen);
      rev        = r;
      start[sel] = 1'b1;
      shift      = 1'b1;
      @(posedge clk); #1;
      start = '0;
      shift = 1'b0;
      k_len = 3'($urandom);
      rev   = 1'($urandom);
      if (k == 0) begin
         observe(sel, '0, '0, 1'b0, 1'b1, "kzero");
         @(posedge clk); #1;
         observe(sel, '0, '0, 1'b0, 1'b0, "kzero_after");
         return;
      end
      observe(sel, '0, '0, 1'b1, 1'b0, "started");
      while (shifts <= t) begin
         gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         for (int g = 0; g < gap; g++) begin
            start[sel] = 1'($urandom_range(0, 1));
            k_len      = 3'($urandom);
            rev        = 1'($urandom);
            @(posedge clk); #1;
            start = '0;
            observe(sel, hx, hw, 1'b1, 1'b0, "stall");
         end
         if (shifts == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            observe(sel, '0, '0, 1'b0, 1'b0, "reset");
            @(posedge clk); #1;
            observe(sel, '0, '0, 1'b0, 1'b0, "reset_after");
            return;
         end
         shift = 1'b1;
         @(posedge clk); #1;
         shift = 1'b0;
         shifts++;
         if (shifts <= t) begin
            hx = exp_x(sel, shifts - 1, k, r);
            hw = exp_w(sel, shifts - 1, k, r);
            observe(sel, hx, hw, 1'b1, 1'b0, "beat");
         end else begin
            observe(sel, '0, '0, 1'b0, 1'b1, "flush");
         end
      end
      @(posedge clk); #1;
      observe(sel, '0, '0, 1'b0, 1'b0, "idle");
   endtask

   initial begin
      rst   = 1'b1;
      start = '0;
      k_len = '0;
      rev   = 1'b0;
      shift = 1'b0;
      load_matrix(1'b0);
      repeat (2) @(posedge clk);
      #1;
      observe(0, '0, '0, 1'b0, 1'b0, "rst0");
      observe(1, '0, '0, 1'b0, 1'b0, "rst1");
      rst = 1'b0;
      @(posedge clk); #1;

      run(0, 4, 1'b0, 0, -1);
      run(1, 4, 1'b0, 0, -1);
      run(0, 3, 1'b1, 0, -1);
      run(1, 3, 1'b1, 0, -1);
      run(0, 7, 1'b0, 0, -1);
      run(0, 0, 1'b0, 0, -1);
      run(1, 0, 1'b1, 0, -1);
      run(0, 4, 1'b0, 5, -1);
      run(1, 4, 1'b1, 5, -1);
      run(0, 4, 1'b0, 0, 2);
      run(0, 4, 1'b0, 0, -1);
      run(1, 4, 1'b0, 3, 2);
      run(1, 4, 1'b0, 0, -1);

      for (int n = 0; n < 40; n++) begin
         load_matrix(1'b1);
         run(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 5)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
